// File: rtl/rv32_pkg.sv
// Constants shared by the RV32 front end: reset/NOP values, fetch FSM
// encodings and the major opcodes decode also switches on.
package rv32_pkg;

  localparam logic [31:0] RV32_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RV32_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FETCH_IDLE = 2'd0;
  localparam fetch_state_t FETCH_REQ  = 2'd1;
  localparam fetch_state_t FETCH_HOLD = 2'd2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory read port. A transfer happens in any cycle where req and
// ack are both high; addr is held stable from the first req cycle until ack.
interface ifetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_skid.sv
// One-entry pc/inst holding buffer used while decode stalls.
// Priority: clear over load over drain.
module fetch_skid
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      inst_d  = load_inst;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= RV32_RESET_PC;
      inst_q  <= RV32_NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign inst  = inst_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: sequential word fetch, stall skid buffer and
// jump redirect with discard of in-flight data.
module ifetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RV32_RESET_PC,
  parameter logic [31:0] NOP_INST = RV32_NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         jump,
  input  logic [31:0]  jump_addr,
  ifetch_if.master     imem,
  output logic [31:0]  pc,
  output logic [31:0]  inst,
  output logic         inst_valid,
  output logic         misalign,
  output fetch_state_t state_dbg
);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  tgt_q, tgt_d;
  logic         inst_valid_q, inst_valid_d;
  logic         misalign_q, misalign_d;
  logic         drop_q, drop_d;

  logic         skid_load, skid_drain, skid_clear, skid_valid;
  logic [31:0]  skid_pc, skid_inst;
  logic         req, accept;
  logic [31:0]  jump_tgt;

  assign req      = (state_q == FETCH_REQ);
  assign accept   = req && imem.ack;
  assign jump_tgt = word_align(jump_addr);

  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .drain     (skid_drain),
    .clear     (skid_clear),
    .load_pc   (fetch_pc_q),
    .load_inst (imem.rdata),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    tgt_d        = tgt_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;
    misalign_d   = jump && (jump_addr[1:0] != 2'b00);
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;

    case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
        if (jump) fetch_pc_d = jump_tgt;
      end
      FETCH_REQ: begin
        // Decode consumed whatever it held; show a bubble unless new data lands.
        if (!stall) begin
          inst_valid_d = 1'b0;
          inst_d       = NOP_INST;
        end
        if (accept) begin
          if (jump || drop_q) begin
            fetch_pc_d = jump ? jump_tgt : tgt_q;
            drop_d     = 1'b0;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (!stall) begin
              pc_d         = fetch_pc_q;
              inst_d       = imem.rdata;
              inst_valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = FETCH_HOLD;
            end
          end
        end else if (jump) begin
          // The address must stay put until memory answers; remember the target.
          drop_d = 1'b1;
          tgt_d  = jump_tgt;
        end
      end
      FETCH_HOLD: begin
        if (jump) begin
          fetch_pc_d = jump_tgt;
          state_d    = FETCH_REQ;
        end else if (!stall) begin
          pc_d         = skid_pc;
          inst_d       = skid_inst;
          inst_valid_d = skid_valid;
          skid_drain   = 1'b1;
          state_d      = FETCH_REQ;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (jump) begin
      pc_d         = 32'd0;
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
      skid_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_IDLE;
      fetch_pc_q   <= RESET_PC;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      tgt_q        <= RESET_PC;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      tgt_q        <= tgt_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
      drop_q       <= drop_d;
    end
  end

  assign imem.req   = req;
  assign imem.addr  = fetch_pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign misalign   = misalign_q;
  assign state_dbg  = state_q;

endmodule
